mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory bus between an instruction-fetch requester
// and a data (load/store) requester. Data accesses win on simultaneous
// requests. Each transaction goes IDLE -> *_BUSY -> *_RESP -> IDLE, and the
// requester's stall drops only during the matching *_RESP cycle.
//
// Optional feature: define MEM_ARB_IBUF_EN to build in a one-entry fetch
// buffer. A fetch whose aligned address matches the buffered line is then
// answered straight from the fetch register without a bus transaction. The
// default build (macro undefined) sends every fetch to the bus and ignores
// fence_flush.

module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,

    // Instruction fetch side
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   pc,
    output logic                    if_stall,
    output logic [31:0]             inst,

    // Data side
    input  logic                    mem_ren,
    input  logic                    mem_wen,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wmask,
    output logic                    mem_stall,
    output logic [DATA_WIDTH-1:0]   rdata,

    // Fetch buffer invalidate
    input  logic                    fence_flush,

    // Memory bus
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    output logic [DATA_WIDTH/8-1:0] bus_wmask,
    input  logic                    bus_ack,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);

    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(MASK_W);
    localparam int TAG_W  = ADDR_WIDTH - 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_BUSY = 3'd1,
        I_BUSY = 3'd2,
        D_RESP = 3'd3,
        I_RESP = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Latched bus request fields; held constant for the whole *_BUSY phase
    logic [ADDR_WIDTH-1:0] bus_addr_q;
    logic                  bus_we_q;
    logic [DATA_WIDTH-1:0] bus_wdata_q;
    logic [MASK_W-1:0]     bus_wmask_q;

    // Response registers
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] fetch_q;

    // Decoded request / handshake terms
    logic                  data_req;
    logic                  ibuf_hit;
    logic                  d_ack;
    logic                  i_ack;
    logic                  start_data;
    logic                  start_fetch_bus;
    logic [ADDR_WIDTH-1:0] fetch_addr;

    assign data_req = mem_ren | mem_wen;

    // Acks only mean something while a bus transaction is outstanding
    assign d_ack = (state_q == D_BUSY) && bus_ack;
    assign i_ack = (state_q == I_BUSY) && bus_ack;

    // Fetch address rounded down to a bus-word boundary
    assign fetch_addr = pc & ~{{(ADDR_WIDTH-OFF_W){1'b0}}, {OFF_W{1'b1}}};

    assign start_data      = (state_q == IDLE) && data_req;
    assign start_fetch_bus = (state_q == IDLE) && !data_req && if_req && !ibuf_hit;

`ifdef MEM_ARB_IBUF_EN
    // One-entry fetch buffer: the fetch register holds the data, this adds
    // a valid bit and the aligned tag of the line it holds.
    logic             ibuf_valid_q, ibuf_valid_d;
    logic [TAG_W-1:0] ibuf_tag_q, ibuf_tag_d;
    logic             ibuf_clear;

    assign ibuf_hit = ibuf_valid_q && (ibuf_tag_q == pc[ADDR_WIDTH-1:3]);

    // A store that hits the buffered line (or a fence) makes it stale
    assign ibuf_clear = fence_flush ||
                        (d_ack && bus_we_q && (bus_addr_q[ADDR_WIDTH-1:3] == ibuf_tag_q));

    // Buffer update: fill on fetch ack, clear wins over fill in the same cycle
    always_comb begin
        ibuf_valid_d = ibuf_valid_q;
        ibuf_tag_d   = ibuf_tag_q;
        if (i_ack) begin
            ibuf_valid_d = 1'b1;
            ibuf_tag_d   = bus_addr_q[ADDR_WIDTH-1:3];
        end
        if (ibuf_clear) begin
            ibuf_valid_d = 1'b0;
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ibuf_valid_q <= 1'b0;
            ibuf_tag_q   <= '0;
        end else begin
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_tag_q   <= ibuf_tag_d;
        end
    end
`else
    // No buffer: every fetch goes to the bus and fence_flush has no effect
    logic unused_fence_flush;

    assign ibuf_hit           = 1'b0;
    assign unused_fence_flush = fence_flush;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; data wins over fetch when both ask in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (data_req) begin
                    state_d = D_BUSY;
                end else if (if_req) begin
                    state_d = ibuf_hit ? I_RESP : I_BUSY;
                end
            end
            D_BUSY: begin
                if (bus_ack) begin
                    state_d = D_RESP;
                end
            end
            I_BUSY: begin
                if (bus_ack) begin
                    state_d = I_RESP;
                end
            end
            D_RESP:  state_d = IDLE;
            I_RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: bus request and requester stalls
    always_comb begin
        bus_req   = (state_q == D_BUSY) || (state_q == I_BUSY);
        mem_stall = data_req && (state_q != D_RESP);
        if_stall  = if_req && (state_q != I_RESP);
    end

    // Capture the bus request fields when a bus transaction starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
        end else if (start_data) begin
            bus_addr_q  <= addr;
            bus_we_q    <= mem_wen;
            bus_wdata_q <= wdata;
            bus_wmask_q <= wmask;
        end else if (start_fetch_bus) begin
            bus_addr_q  <= fetch_addr;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
        end
    end

    // Load result: updated only by a read ack, stores leave it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (d_ack && !bus_we_q) begin
            rdata_q <= bus_rdata;
        end
    end

    // Fetch register: the whole bus word of the last fetched line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_q <= '0;
        end else if (i_ack) begin
            fetch_q <= bus_rdata;
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_we    = bus_we_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wmask = bus_wmask_q;
    assign rdata     = rdata_q;

    // Instruction select: pc[2] picks the upper or lower word of the line
    generate
        if (DATA_WIDTH >= 64) begin : g_inst_sel64
            assign inst = pc[2] ? fetch_q[63:32] : fetch_q[31:0];
        end else begin : g_inst_sel32
            assign inst = fetch_q[31:0];
        end
    endgenerate

endmodule
